// File: rtl/shake_squeeze_if.sv
// Bundles the squeeze-side handshakes of shake_squeeze: the start/length
// command, the rate-block request to the permutation core and the output word
// stream towards the consumer.
interface shake_squeeze_if #(
  parameter int RATE  = 1088,
  parameter int W     = 64,
  parameter int LEN_W = 16
);
  logic             start;
  logic [LEN_W-1:0] out_len;
  logic             busy;
  logic             blk_req;
  logic             blk_first;
  logic             blk_valid;
  logic [RATE-1:0]  blk_data;
  logic [W-1:0]     dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_last;
  logic [6:0]       dout_bits;
  logic             done;

  // Environment side: issues commands, serves blocks, consumes words.
  modport master (
    output start, out_len, blk_valid, blk_data, dout_ready,
    input  busy, blk_req, blk_first, dout, dout_valid, dout_last, dout_bits, done
  );

  // Serializer side.
  modport slave (
    input  start, out_len, blk_valid, blk_data, dout_ready,
    output busy, blk_req, blk_first, dout, dout_valid, dout_last, dout_bits, done
  );
endinterface

// File: rtl/shake_squeeze.sv
// SHAKE256 squeeze serializer: pulls rate blocks from the permutation core and
// streams them MSB-first as W-bit words until out_len bits have been emitted.
// The last word carries only the remaining bits, left-aligned, zero below.
// All outputs come straight from flops, computed from next-state values.
module shake_squeeze #(
  parameter int RATE  = 1088,
  parameter int W     = 64,
  parameter int LEN_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  shake_squeeze_if.slave bus
);

  localparam int NWORDS = RATE / W;
  localparam int WIDX_W = $clog2(NWORDS);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BLK = 2'd1,
    ST_STREAM   = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  // Keeps the top nbits bits of a word; nbits==W keeps everything.
  function automatic logic [W-1:0] keep_mask(input logic [6:0] nbits);
    return ~({W{1'b1}} >> nbits);
  endfunction

  state_t            state_q, state_d;
  logic [RATE-1:0]   sreg_q, sreg_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic              first_q, first_d;

  logic              busy_q, busy_d;
  logic              blk_req_q, blk_req_d;
  logic              blk_first_q, blk_first_d;
  logic [W-1:0]      dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              dout_last_q, dout_last_d;
  logic [6:0]        dout_bits_q, dout_bits_d;
  logic              done_q, done_d;

  logic              cur_last_s;
  logic [6:0]        cur_bits_s;
  logic              xfer_s;
  logic              zero_start_s;
  logic              nxt_last_s;
  logic [6:0]        nxt_bits_s;

  // The word currently on dout is the final one once at most W bits remain.
  assign cur_last_s = (rem_q <= LEN_W'(W));
  assign cur_bits_s = cur_last_s ? rem_q[6:0] : 7'(W);
  assign xfer_s     = (state_q == ST_STREAM) && bus.dout_ready;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    rem_d        = rem_q;
    widx_d       = widx_q;
    first_d      = first_q;
    zero_start_s = 1'b0;
    nxt_last_s   = 1'b0;
    nxt_bits_s   = 7'd0;
    busy_d       = 1'b0;
    blk_req_d    = 1'b0;
    blk_first_d  = 1'b0;
    dout_d       = {W{1'b0}};
    dout_valid_d = 1'b0;
    dout_last_d  = 1'b0;
    dout_bits_d  = 7'd0;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.out_len != {LEN_W{1'b0}}) begin
            rem_d   = bus.out_len;
            first_d = 1'b1;
            state_d = ST_WAIT_BLK;
          end else begin
            zero_start_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_BLK: begin
        if (bus.blk_valid) begin
          sreg_d  = bus.blk_data;
          widx_d  = {WIDX_W{1'b0}};
          first_d = 1'b0;
          state_d = ST_STREAM;
        end else begin
          state_d = ST_WAIT_BLK;
        end
      end
      ST_STREAM: begin
        if (xfer_s) begin
          sreg_d = {sreg_q[RATE-W-1:0], {W{1'b0}}};
          widx_d = widx_q + WIDX_W'(1);
          rem_d  = rem_q - LEN_W'(cur_bits_s);
          if (cur_last_s) begin
            state_d = ST_DONE;
          end else if (widx_q == WIDX_W'(NWORDS - 1)) begin
            state_d = ST_WAIT_BLK;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs registered from the state being entered, so they line up with it.
    nxt_last_s = (rem_d <= LEN_W'(W));
    if (nxt_last_s) begin
      nxt_bits_s = rem_d[6:0];
    end else begin
      nxt_bits_s = 7'(W);
    end

    busy_d    = (state_d != ST_IDLE);
    blk_req_d = (state_d == ST_WAIT_BLK);
    if (state_d == ST_WAIT_BLK) begin
      blk_first_d = first_d;
    end else begin
      blk_first_d = 1'b0;
    end

    if (state_d == ST_STREAM) begin
      dout_valid_d = 1'b1;
      dout_last_d  = nxt_last_s;
      dout_bits_d  = nxt_bits_s;
      dout_d       = sreg_d[RATE-1 -: W] & keep_mask(nxt_bits_s);
    end else begin
      dout_valid_d = 1'b0;
      dout_last_d  = 1'b0;
      dout_bits_d  = 7'd0;
      dout_d       = {W{1'b0}};
    end

    done_d = (state_d == ST_DONE) || zero_start_s;
  end

  // State, datapath and output registers; reset abandons any squeeze.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sreg_q       <= {RATE{1'b0}};
      rem_q        <= {LEN_W{1'b0}};
      widx_q       <= {WIDX_W{1'b0}};
      first_q      <= 1'b0;
      busy_q       <= 1'b0;
      blk_req_q    <= 1'b0;
      blk_first_q  <= 1'b0;
      dout_q       <= {W{1'b0}};
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      dout_bits_q  <= 7'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      rem_q        <= rem_d;
      widx_q       <= widx_d;
      first_q      <= first_d;
      busy_q       <= busy_d;
      blk_req_q    <= blk_req_d;
      blk_first_q  <= blk_first_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      dout_bits_q  <= dout_bits_d;
      done_q       <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.blk_req    = blk_req_q;
  assign bus.blk_first  = blk_first_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_last  = dout_last_q;
  assign bus.dout_bits  = dout_bits_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_shake_squeeze.sv
// Bench for shake_squeeze: directed squeezes from the test plan plus random
// lengths, blocks and consumer backpressure, checked against a model that
// treats the output as the concatenation of the supplied blocks.
module tb_shake_squeeze;

  localparam int RATE  = 1088;
  localparam int W     = 64;
  localparam int LEN_W = 16;
  localparam int NW    = RATE / W;
  localparam int MAXB  = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  shake_squeeze_if #(.RATE(RATE), .W(W), .LEN_W(LEN_W)) bus ();

  shake_squeeze #(.RATE(RATE), .W(W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [RATE-1:0] blocks [MAXB];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output bit stream = blocks in order, each read from bit RATE-1 downwards.
  function automatic logic [63:0] model_word(input int len, input int k);
    logic [RATE-1:0] blk;
    logic [63:0]     w;
    int              b;
    int              j;
    int              bits;
    b    = k / NW;
    j    = k % NW;
    blk  = blocks[b];
    w    = blk[RATE-1-j*W -: W];
    bits = len - k * W;
    if (bits < W) w = w & ~((64'd1 << (W - bits)) - 64'd1);
    return w;
  endfunction

  task automatic fill_blocks(input bit pattern);
    for (int b = 0; b < MAXB; b++) begin
      for (int i = 0; i < NW; i++) begin
        if (pattern)
          blocks[b][RATE-1-i*W -: W] = 64'hA5A5_0000_0000_0000 + (64'(b) << 32) + 64'(i);
        else
          blocks[b][RATE-1-i*W -: W] = {$urandom, $urandom};
      end
    end
  endtask

  // mode: 0 always ready, 1 random ready, 2 ready pattern 1,0,0,...
  task automatic run(input int len, input int mode, input bit inject, input int abort_at);
    int nw = 0;
    int nblk = 0;
    int cyc = 0;
    int tog = 0;
    int bits;
    bit lst;
    bit rdy;
    bit acc_prev = 1'b0;
    bit last_prev = 1'b0;
    bit exh_prev = 1'b0;
    bit fin = 1'b0;
    int exp_words = (len + W - 1) / W;
    int exp_blks  = (len + RATE - 1) / RATE;

    @(negedge clk);
    bus.start   = 1'b1;
    bus.out_len = LEN_W'(len);
    while (!fin) begin
      @(negedge clk);
      cyc++;
      bus.start      = 1'b0;
      bus.blk_valid  = 1'b0;
      bus.dout_ready = 1'b0;
      check_eq("done", 64'(bus.done), 64'(last_prev));
      if (last_prev) fin = 1'b1;
      if (acc_prev) check_eq("blk_to_dout_latency", 64'(bus.dout_valid), 64'd1);
      if (exh_prev) check_eq("req_after_exhaust", 64'(bus.blk_req), 64'd1);
      acc_prev  = 1'b0;
      last_prev = 1'b0;
      exh_prev  = 1'b0;
      if (!fin) check_eq("busy", 64'(bus.busy), 64'd1);
      if (bus.blk_req) begin
        check_eq("no_extra_req", 64'(nblk < exp_blks), 64'd1);
        check_eq("blk_first", 64'(bus.blk_first), 64'(nblk == 0));
        if ($urandom_range(0, 2) != 0 && nblk < MAXB) begin
          bus.blk_valid = 1'b1;
          bus.blk_data  = blocks[nblk];
          nblk++;
          acc_prev = 1'b1;
        end
      end
      if (bus.dout_valid) begin
        if (abort_at >= 0 && nw == abort_at) begin
          rst = 1'b1;
          #1;
          check_eq("rst_dout", bus.dout, 64'd0);
          check_eq("rst_ctl", 64'({bus.busy, bus.blk_req, bus.blk_first, bus.dout_valid,
                                   bus.dout_last, bus.done, bus.dout_bits}), 64'd0);
          repeat (3) begin
            @(negedge clk);
            check_eq("rst_no_done", 64'(bus.done), 64'd0);
          end
          rst = 1'b0;
          return;
        end
        bits = len - nw * W;
        lst  = (bits <= W);
        if (!lst) bits = W;
        check_eq("dout", bus.dout, model_word(len, nw));
        check_eq("dout_last", 64'(bus.dout_last), 64'(lst));
        check_eq("dout_bits", 64'(bus.dout_bits), 64'(bits));
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = 1'($urandom_range(0, 1));
          default: rdy = (tog % 3 == 0);
        endcase
        tog++;
        bus.dout_ready = rdy;
        if (rdy) begin
          nw++;
          last_prev = lst;
          exh_prev  = !lst && (nw % NW == 0);
        end
        if (inject && nw == 2) begin
          bus.start   = 1'b1;
          bus.out_len = 16'd64;
        end
      end
      if (cyc > 6000) begin
        check_eq("timeout", 64'd0, 64'd1);
        fin = 1'b1;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("idle_busy", 64'(bus.busy), 64'd0);
    check_eq("idle_done", 64'(bus.done), 64'd0);
    check_eq("word_count", 64'(nw), 64'(exp_words));
    check_eq("block_count", 64'(nblk), 64'(exp_blks));
  endtask

  task automatic zero_len();
    @(negedge clk);
    bus.start   = 1'b1;
    bus.out_len = 16'd0;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("zero_done", 64'(bus.done), 64'd1);
    check_eq("zero_busy", 64'(bus.busy), 64'd0);
    check_eq("zero_req", 64'(bus.blk_req), 64'd0);
    @(negedge clk);
    check_eq("zero_done_clear", 64'(bus.done), 64'd0);
    check_eq("zero_busy2", 64'(bus.busy), 64'd0);
    check_eq("zero_req2", 64'(bus.blk_req), 64'd0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.out_len    = 16'd0;
    bus.blk_valid  = 1'b0;
    bus.blk_data   = {RATE{1'b0}};
    bus.dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_dout", bus.dout, 64'd0);
    check_eq("reset_ctl", 64'({bus.busy, bus.blk_req, bus.blk_first, bus.dout_valid,
                               bus.dout_last, bus.done, bus.dout_bits}), 64'd0);
    rst = 1'b0;

    fill_blocks(1'b1);
    run(256, 0, 1'b0, -1);
    run(1088, 0, 1'b0, -1);
    run(1100, 0, 1'b0, -1);
    run(320, 2, 1'b0, -1);
    zero_len();
    run(700, 1, 1'b1, -1);

    fill_blocks(1'b0);
    run(2500, 1, 1'b0, 5);
    run(64, 0, 1'b0, -1);

    for (int t = 0; t < 8; t++) begin
      fill_blocks(1'b0);
      run($urandom_range(1, MAXB * RATE), $urandom_range(0, 2), 1'b0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
